// File: rtl/pbvi_backup_engine.sv
// Time-multiplexed PBVI backup: per belief point, picks the best projected alpha
// vector per (action, observation), adds the reward, and emits the best action.
module pbvi_backup_engine #(
  parameter  int W   = 16,
  parameter  int S   = 2,
  parameter  int A   = 3,
  parameter  int O   = 2,
  parameter  int K   = 16,
  parameter  int P   = 16,
  localparam int AW  = (A * O * K > 1) ? $clog2(A * O * K) : 1,
  localparam int PW  = (P > 1) ? $clog2(P) : 1,
  localparam int ACW = (A > 1) ? $clog2(A) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               gam_rd_en,
  output logic [AW-1:0]      gam_addr,
  input  logic [S*W-1:0]     gam_rd_data,
  input  logic [A*S*W-1:0]   reward_flat,
  input  logic [P*S*W-1:0]   belief_flat,
  output logic               out_valid,
  output logic [PW-1:0]      out_point,
  output logic [ACW-1:0]     out_action,
  output logic [S*W-1:0]     out_alpha
);

  localparam int KW = (K > 1) ? $clog2(K) : 1;
  localparam int OW = (O > 1) ? $clog2(O) : 1;
  localparam int VW = S * W;
  localparam int DW = 2 * W + $clog2(S);

  typedef enum logic [2:0] {IDLE, INIT_A, SCAN, DRAIN, ACC, EVAL, EMIT, DONE} state_t;

  state_t          state, state_nx;
  logic [PW-1:0]   p;
  logic [ACW-1:0]  a;
  logic [OW-1:0]   o;
  logic [KW-1:0]   k;
  logic            cand_valid, cand_first;
  logic [DW-1:0]   best_dot, best_val;
  logic [VW-1:0]   best_vec, acc, best_alpha;
  logic [ACW-1:0]  best_act;
  logic [AW-1:0]   addr_q, addr_cur;
  logic [VW-1:0]   bel_cur;
  logic [DW-1:0]   cand_dot, eval_val;
  logic            eval_take;

  // Full-precision dot product; the accumulator is wide enough that nothing truncates.
  function automatic logic [DW-1:0] dot(input logic [VW-1:0] x, input logic [VW-1:0] y);
    logic [DW-1:0] sum;
    sum = '0;
    for (int s = 0; s < S; s++)
      sum += DW'(x[s*W +: W]) * DW'(y[s*W +: W]);
    return sum;
  endfunction

  function automatic logic [VW-1:0] sat_add(input logic [VW-1:0] x, input logic [VW-1:0] y);
    logic [VW-1:0] r;
    logic [W:0]    sum;
    r = '0;
    for (int s = 0; s < S; s++) begin
      sum = {1'b0, x[s*W +: W]} + {1'b0, y[s*W +: W]};
      r[s*W +: W] = sum[W] ? {W{1'b1}} : sum[W-1:0];
    end
    return r;
  endfunction

  assign bel_cur   = belief_flat[int'(p)*VW +: VW];
  assign addr_cur  = AW'((int'(a) * O + int'(o)) * K + int'(k));
  assign cand_dot  = dot(bel_cur, gam_rd_data);
  assign eval_val  = dot(bel_cur, acc);
  assign eval_take = (a == '0) || (eval_val > best_val);

  assign busy      = (state != IDLE) && (state != DONE);
  assign done      = (state == DONE);
  assign out_valid = (state == EMIT);
  assign gam_rd_en = (state == SCAN);
  assign gam_addr  = (state == SCAN) ? addr_cur : addr_q;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = INIT_A;
      INIT_A:  state_nx = SCAN;
      SCAN:    if (int'(k) == K - 1) state_nx = DRAIN;
      DRAIN:   state_nx = ACC;
      ACC:     state_nx = (int'(o) == O - 1) ? EVAL : SCAN;
      EVAL:    state_nx = (int'(a) == A - 1) ? EMIT : INIT_A;
      EMIT:    state_nx = (int'(p) == P - 1) ? DONE : INIT_A;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      p          <= '0;
      a          <= '0;
      o          <= '0;
      k          <= '0;
      acc        <= '0;
      addr_q     <= '0;
      best_val   <= '0;
      best_act   <= '0;
      best_alpha <= '0;
      out_point  <= '0;
      out_action <= '0;
      out_alpha  <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (start) begin
          p <= '0;
          a <= '0;
        end
        INIT_A: begin
          acc <= reward_flat[int'(a)*VW +: VW];
          o   <= '0;
          k   <= '0;
        end
        SCAN: begin
          addr_q <= addr_cur;
          if (int'(k) != K - 1) k <= k + 1'b1;
        end
        ACC: begin
          acc <= sat_add(acc, best_vec);
          if (int'(o) != O - 1) begin
            o <= o + 1'b1;
            k <= '0;
          end
        end
        EVAL: begin
          if (eval_take) begin
            best_val   <= eval_val;
            best_act   <= a;
            best_alpha <= acc;
          end
          if (int'(a) == A - 1) begin
            // Outputs are loaded on entry to EMIT and then held until the next point.
            out_point  <= p;
            out_action <= eval_take ? a : best_act;
            out_alpha  <= eval_take ? acc : best_alpha;
          end else begin
            a <= a + 1'b1;
          end
        end
        EMIT: if (int'(p) != P - 1) begin
          p <= p + 1'b1;
          a <= '0;
        end
        default: ;
      endcase
    end
  end

  // Read data returns one cycle after the strobe; the first word of a scan always loads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_valid <= 1'b0;
      cand_first <= 1'b0;
      best_dot   <= '0;
      best_vec   <= '0;
    end else begin
      cand_valid <= (state == SCAN);
      cand_first <= (state == SCAN) && (k == '0);
      if (cand_valid && (cand_first || cand_dot > best_dot)) begin
        best_dot <= cand_dot;
        best_vec <= gam_rd_data;
      end
    end
  end

endmodule

// File: tb/tb_pbvi_backup_engine.sv
// Directed bench for pbvi_backup_engine: scenario table on the default build,
// plus reset-mid-pass, ignored-start and a small alternate-parameter build.
module tb_pbvi_backup_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        busy, done, gam_rd_en, out_valid;
  logic [6:0]  gam_addr;
  logic [31:0] gam_rd_data;
  logic [95:0] reward_flat;
  logic [511:0] belief_flat;
  logic [3:0]  out_point;
  logic [1:0]  out_action;
  logic [31:0] out_alpha;
  logic [31:0] gmem [96];

  // Alternate build: S=3, A=2, O=3, K=4, P=5, all-zero memory/beliefs/rewards.
  logic        start2;
  logic        busy2, done2, gam_rd_en2, out_valid2;
  logic [4:0]  gam_addr2;
  logic [47:0] gam_rd_data2;
  logic [95:0] reward_flat2;
  logic [239:0] belief_flat2;
  logic [2:0]  out_point2;
  logic [0:0]  out_action2;
  logic [47:0] out_alpha2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pbvi_backup_engine dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .gam_rd_en(gam_rd_en), .gam_addr(gam_addr), .gam_rd_data(gam_rd_data),
    .reward_flat(reward_flat), .belief_flat(belief_flat),
    .out_valid(out_valid), .out_point(out_point), .out_action(out_action),
    .out_alpha(out_alpha)
  );

  pbvi_backup_engine #(.W(16), .S(3), .A(2), .O(3), .K(4), .P(5)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .busy(busy2), .done(done2),
    .gam_rd_en(gam_rd_en2), .gam_addr(gam_addr2), .gam_rd_data(gam_rd_data2),
    .reward_flat(reward_flat2), .belief_flat(belief_flat2),
    .out_valid(out_valid2), .out_point(out_point2), .out_action(out_action2),
    .out_alpha(out_alpha2)
  );

  // Synchronous-read gamma memory model: data one cycle after the strobe.
  always @(posedge clk) if (gam_rd_en) gam_rd_data <= gmem[gam_addr];

  typedef struct {
    string       name;
    int          gmode;
    int          bmode;
    logic [31:0] rew0;
    logic [31:0] rew2;
    logic [1:0]  exp_act;
    logic [31:0] exp_alpha;
  } vec_t;

  vec_t tbl[4];

  int          r_valid, r_done_cyc, r_rd, r_done;
  logic        r_busy1, r_busy_done;
  logic [3:0]  r_pt[16];
  logic [1:0]  r_act[16];
  logic [31:0] r_alpha[16];

  function automatic logic [31:0] vec2(input logic [15:0] e0, input logic [15:0] e1);
    return {e1, e0};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic setup(input vec_t v);
    logic [15:0] kk;
    for (int i = 0; i < 96; i++) begin
      kk = 16'(i % 16);
      case (v.gmode)
        0: gmem[i] = vec2(16'h4000, 16'h4000);
        1: gmem[i] = (i >= 32 && i < 64) ? vec2(kk << 8, 16'h0000) : 32'h0;
        2: gmem[i] = vec2(16'h2000, 16'h2000);
        default: gmem[i] = kk[0] ? vec2(16'h0800, kk << 8) : vec2(16'h1000, kk << 8);
      endcase
    end
    for (int p = 0; p < 16; p++) begin
      logic [15:0] pp;
      pp = 16'(p * 16'h1000);
      case (v.bmode)
        0: belief_flat[p*32 +: 32] = vec2(pp, 16'hFFFF - pp);
        1: belief_flat[p*32 +: 32] = vec2(16'h8000, 16'h7FFF);
        2: belief_flat[p*32 +: 32] = vec2(16'h8000, 16'h8000);
        default: belief_flat[p*32 +: 32] = vec2(16'h1000, 16'h0000);
      endcase
    end
    reward_flat = {v.rew2, 32'h0, v.rew0};
  endtask

  // Start a pass and observe it at negedges; cycle 1 is the first INIT_A cycle.
  task automatic run_pass(input bit inject);
    int cyc;
    r_valid = 0; r_done_cyc = 0; r_rd = 0; r_done = 0; r_busy_done = 1'b1;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    cyc = 1;
    r_busy1 = busy;
    while (cyc < 3000) begin
      if (gam_rd_en) r_rd++;
      if (out_valid) begin
        if (r_valid < 16) begin
          r_pt[r_valid]    = out_point;
          r_act[r_valid]   = out_action;
          r_alpha[r_valid] = out_alpha;
        end
        r_valid++;
      end
      if (done) begin
        r_done++;
        if (r_done_cyc == 0) begin
          r_done_cyc  = cyc;
          r_busy_done = busy;
        end
      end
      start = inject && (cyc == 100 || cyc == 700 || done);
      if (r_done_cyc != 0 && cyc >= r_done_cyc + 20) break;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
  endtask

  task automatic check_pass(input vec_t v);
    check({v.name, " valid_count"}, 64'(r_valid), 64'd16);
    check({v.name, " done_cycle"}, 64'(r_done_cyc), 64'd1841);
    check({v.name, " rd_en_cycles"}, 64'(r_rd), 64'd1536);
    check({v.name, " done_pulses"}, 64'(r_done), 64'd1);
    for (int p = 0; p < 16; p++) begin
      check($sformatf("%s p%0d point", v.name, p), 64'(r_pt[p]), 64'(p));
      check($sformatf("%s p%0d action", v.name, p), 64'(r_act[p]), 64'(v.exp_act));
      check($sformatf("%s p%0d alpha", v.name, p), 64'(r_alpha[p]), 64'(v.exp_alpha));
    end
  endtask

  initial begin
    int cyc, errs;
    tbl[0] = '{"tiebreak", 0, 0, 32'h0, 32'h0, 2'd0, vec2(16'h8000, 16'h8000)};
    tbl[1] = '{"argmax", 1, 1, 32'h0, 32'h0, 2'd1, vec2(16'h1E00, 16'h0000)};
    tbl[2] = '{"saturate", 2, 2, vec2(16'hF000, 16'hF000), 32'h0, 2'd0, vec2(16'hFFFF, 16'hFFFF)};
    tbl[3] = '{"k_tie", 3, 3, 32'h0, vec2(16'h0001, 16'h0000), 2'd2, vec2(16'h2001, 16'h0000)};

    rst_n = 1'b0; start = 1'b0; start2 = 1'b0;
    gam_rd_data = '0; gam_rd_data2 = '0; reward_flat2 = '0; belief_flat2 = '0;
    setup(tbl[0]);
    #23;
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(done), 64'd0);
    check("rst gam_rd_en", 64'(gam_rd_en), 64'd0);
    check("rst gam_addr", 64'(gam_addr), 64'd0);
    check("rst out_valid", 64'(out_valid), 64'd0);
    check("rst out_point", 64'(out_point), 64'd0);
    check("rst out_action", 64'(out_action), 64'd0);
    check("rst out_alpha", 64'(out_alpha), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Scenario table; the first pass also fires stray starts while busy and in DONE.
    for (int i = 0; i < 4; i++) begin
      setup(tbl[i]);
      run_pass(i == 0);
      if (i == 0) begin
        check("busy at INIT_A", 64'(r_busy1), 64'd1);
        check("busy in DONE", 64'(r_busy_done), 64'd0);
      end
      check_pass(tbl[i]);
    end

    // Reset during point 5 SCAN (point 5 INIT_A is cycle 576).
    setup(tbl[0]);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    cyc = 1;
    while (cyc < 580) begin
      @(negedge clk);
      cyc++;
    end
    check("mid scan rd_en", 64'(gam_rd_en), 64'd1);
    check("mid scan last point", 64'(out_point), 64'd4);
    #2 rst_n = 1'b0;
    #1;
    check("midrst busy", 64'(busy), 64'd0);
    check("midrst gam_rd_en", 64'(gam_rd_en), 64'd0);
    check("midrst out_valid", 64'(out_valid), 64'd0);
    check("midrst out_point", 64'(out_point), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    errs = 0;
    repeat (30) begin
      @(negedge clk);
      if (done || busy) errs++;
    end
    check("no done after reset", 64'(errs), 64'd0);
    run_pass(1'b0);
    check_pass(tbl[0]);

    // Alternate build: L = 2*(3*6+2)+1 = 41, pass = 205, done in cycle 206.
    @(negedge clk) start2 = 1'b1;
    @(negedge clk) start2 = 1'b0;
    cyc = 1; r_valid = 0; r_rd = 0; r_done_cyc = 0;
    while (cyc < 1000 && r_done_cyc == 0) begin
      if (gam_rd_en2) r_rd++;
      if (out_valid2) begin
        r_valid++;
        r_pt[0] = 4'(out_point2);
        r_act[0] = 2'(out_action2);
      end
      if (done2) r_done_cyc = cyc;
      @(negedge clk);
      cyc++;
    end
    check("alt done_cycle", 64'(r_done_cyc), 64'd206);
    check("alt valid_count", 64'(r_valid), 64'd5);
    check("alt rd_en_cycles", 64'(r_rd), 64'd120);
    check("alt last point", 64'(r_pt[0]), 64'd4);
    check("alt action", 64'(r_act[0]), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
